ldpc_concatenator_n: RTL and testbench

LDPC_CONCATENATOR_N -- requirements
Module: ldpc_concatenator_n

---
 rtl/ldpc_concat_pkg.sv | 31 +++
 rtl/ldpc_concat_out_reg.sv | 57 +++++
 rtl/ldpc_concatenator_n.sv | 212 +++++++++++++++++++++
 tb/tb_ldpc_concatenator_n.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_concat_pkg.sv
// Shared types and parameter-field helpers for the LDPC frame concatenator.
// The RATIOS/LENGTHS parameters are flat vectors with one fixed-width field
// per channel. The helpers take them zero-extended to the maximum channel
// count, so they work for any NUM_CH.
package ldpc_concat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int RATIO_W  = 8;
  localparam int LENGTH_W = 16;
  localparam int MAX_CH   = 8;

  function automatic logic [RATIO_W-1:0] ratio_of(
    input logic [MAX_CH*RATIO_W-1:0] ratios,
    input int                        c
  );
    return ratios[c*RATIO_W +: RATIO_W];
  endfunction

  function automatic logic [LENGTH_W-1:0] length_of(
    input logic [MAX_CH*LENGTH_W-1:0] lengths,
    input int                         c
  );
    return lengths[c*LENGTH_W +: LENGTH_W];
  endfunction

endpackage

// File: rtl/ldpc_concat_out_reg.sv
// Single-entry valid/ready output register carrying a data word and a last
// flag. o_free tells the producer it may load this cycle. Contents are held
// while the word is valid and downstream is not ready.
module ldpc_concat_out_reg
  import ldpc_concat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Load a new word, or drop valid once downstream has taken the current one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = i_last;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_free  = !valid_q || i_ready;

endmodule

// File: rtl/ldpc_concatenator_n.sv
// LDPC frame concatenator. Each frame walks the enabled channels in ascending
// order. It takes LENGTHS[c] output words from each channel by splitting its
// wide input words into RATIOS[c] subwords, emitted LSB first.
// Optional build macro: LDPC_CONCAT_STATS_EN adds o_frame_count and o_stall.
//
// state    | meaning
// ST_IDLE  | between frames; latch channel mask, pick lowest enabled channel
// ST_FETCH | waiting for an input word on the current channel
// ST_SHIFT | emitting the remaining subwords of the fetched word
module ldpc_concatenator_n
  import ldpc_concat_pkg::*;
#(
  parameter int                          NUM_CH    = 3,
  parameter int                          OUT_WIDTH = 8,
  parameter int                          CH_WIDTH  = 96,
  parameter logic [NUM_CH*RATIO_W-1:0]   RATIOS    = {8'd12, 8'd12, 8'd1},
  parameter logic [NUM_CH*LENGTH_W-1:0]  LENGTHS   = {16'd132, 16'd12, 16'd144}
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_CH*CH_WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]          i_in_valid,
  output logic [NUM_CH-1:0]          o_in_ready,
  input  logic [NUM_CH-1:0]          i_ch_enable,
  output logic [OUT_WIDTH-1:0]       o_out_data,
  output logic                       o_out_valid,
  output logic                       o_out_last,
  input  logic                       i_out_ready
`ifdef LDPC_CONCAT_STATS_EN
  ,
  output logic [15:0]                o_frame_count,
  output logic                       o_stall
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [MAX_CH*RATIO_W-1:0]  RATIOS_X  = (MAX_CH*RATIO_W)'(RATIOS);
  localparam logic [MAX_CH*LENGTH_W-1:0] LENGTHS_X = (MAX_CH*LENGTH_W)'(LENGTHS);

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CH_W-1:0]       cur_q, cur_d;
  logic [LENGTH_W-1:0]   cnt_q, cnt_d;
  logic [RATIO_W-1:0]    sub_q, sub_d;
  logic [CH_WIDTH-1:0]   shift_q, shift_d;

  logic                  out_free;
  logic                  load;
  logic [OUT_WIDTH-1:0]  load_data;
  logic                  load_last;
  logic                  emit;

  logic [CH_W-1:0]       first_ch, nxt_ch;
  logic                  first_any, nxt_any;
  logic [RATIO_W-1:0]    cur_ratio;
  logic [LENGTH_W-1:0]   first_len, nxt_len;
  logic [CH_WIDTH-1:0]   cur_word;
  logic                  in_valid_cur;

  // Lowest channel of the incoming mask, and next enabled channel above cur.
  always_comb begin
    first_ch  = '0;
    first_any = 1'b0;
    nxt_ch    = '0;
    nxt_any   = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (i_ch_enable[c]) begin
        first_any = 1'b1;
        first_ch  = CH_W'(c);
      end
      if (mask_q[c] && (c > int'(cur_q))) begin
        nxt_any = 1'b1;
        nxt_ch  = CH_W'(c);
      end
    end
  end

  assign cur_ratio    = ratio_of(RATIOS_X, int'(cur_q));
  assign first_len    = length_of(LENGTHS_X, int'(first_ch));
  assign nxt_len      = length_of(LENGTHS_X, int'(nxt_ch));
  assign cur_word     = i_in_data[int'(cur_q)*CH_WIDTH +: CH_WIDTH];
  assign in_valid_cur = i_in_valid[cur_q];

  // Next-state, counters and output-register load control.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    shift_d    = shift_q;
    o_in_ready = '0;
    emit       = 1'b0;
    load       = 1'b0;
    load_data  = cur_word[OUT_WIDTH-1:0];
    load_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (first_any) begin
          mask_d  = i_ch_enable;
          cur_d   = first_ch;
          cnt_d   = first_len;
          sub_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_in_ready[cur_q] = out_free;
        if (out_free && in_valid_cur) begin
          emit      = 1'b1;
          load_data = cur_word[OUT_WIDTH-1:0];
          shift_d   = cur_word >> OUT_WIDTH;
          sub_d     = RATIO_W'(1);
          if (cur_ratio > RATIO_W'(1)) begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (out_free) begin
          emit      = 1'b1;
          load_data = shift_q[OUT_WIDTH-1:0];
          shift_d   = shift_q >> OUT_WIDTH;
          sub_d     = sub_q + RATIO_W'(1);
          if (sub_q == cur_ratio - RATIO_W'(1)) begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The channel's word budget overrides the subword sequencing: leftover
    // subwords are dropped and the next channel is fetched straight away.
    if (emit) begin
      load  = 1'b1;
      cnt_d = cnt_q - LENGTH_W'(1);
      if (cnt_q == LENGTH_W'(1)) begin
        shift_d = '0;
        sub_d   = '0;
        if (nxt_any) begin
          cur_d   = nxt_ch;
          cnt_d   = nxt_len;
          state_d = ST_FETCH;
        end else begin
          load_last = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    end
  end

  // Sequencer state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      shift_q <= shift_d;
    end
  end

  ldpc_concat_out_reg #(
    .WIDTH (OUT_WIDTH)
  ) u_out_reg (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (load),
    .i_data  (load_data),
    .i_last  (load_last),
    .i_ready (i_out_ready),
    .o_valid (o_out_valid),
    .o_data  (o_out_data),
    .o_last  (o_out_last),
    .o_free  (out_free)
  );

`ifdef LDPC_CONCAT_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count completed frames; the 16-bit wrap is intentional.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (o_out_valid && o_out_last && i_out_ready) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_stall       = (state_q == ST_FETCH) && out_free && !in_valid_cur;
`endif

endmodule

// File: tb/tb_ldpc_concatenator_n.sv
// Bench for ldpc_concatenator_n. It runs two instances: the default
// configuration, and one with channel 2 LENGTH 130. A table of frame
// configurations drives random input words. The expected output stream is
// built from the concatenation rules: per enabled channel in ascending order,
// the first RATIO subwords of each word, LSB first, truncated to LENGTH words.
module tb_ldpc_concatenator_n;

  localparam int NUM_CH    = 3;
  localparam int CH_WIDTH  = 96;
  localparam int OUT_WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH*CH_WIDTH-1:0] in_data   [2];
  logic [NUM_CH-1:0]          in_valid  [2];
  logic [NUM_CH-1:0]          in_ready  [2];
  logic [NUM_CH-1:0]          ch_en     [2];
  logic [OUT_WIDTH-1:0]       out_data  [2];
  logic                       out_valid [2];
  logic                       out_last  [2];
  logic                       out_ready [2];
`ifdef LDPC_CONCAT_STATS_EN
  logic [15:0]                frame_cnt [2];
  logic                       stall     [2];
`endif

  ldpc_concatenator_n dut0 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_in_data   (in_data[0]),
    .i_in_valid  (in_valid[0]),
    .o_in_ready  (in_ready[0]),
    .i_ch_enable (ch_en[0]),
    .o_out_data  (out_data[0]),
    .o_out_valid (out_valid[0]),
    .o_out_last  (out_last[0]),
    .i_out_ready (out_ready[0])
`ifdef LDPC_CONCAT_STATS_EN
    ,
    .o_frame_count (frame_cnt[0]),
    .o_stall       (stall[0])
`endif
  );

  ldpc_concatenator_n #(
    .LENGTHS ({16'd130, 16'd12, 16'd144})
  ) dut1 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_in_data   (in_data[1]),
    .i_in_valid  (in_valid[1]),
    .o_in_ready  (in_ready[1]),
    .i_ch_enable (ch_en[1]),
    .o_out_data  (out_data[1]),
    .o_out_valid (out_valid[1]),
    .o_out_last  (out_last[1]),
    .i_out_ready (out_ready[1])
`ifdef LDPC_CONCAT_STATS_EN
    ,
    .o_frame_count (frame_cnt[1]),
    .o_stall       (stall[1])
`endif
  );

  typedef struct {
    int          inst;
    logic [2:0]  mask;
    logic [2:0]  nxt;
    bit          tog;
    int          vpct;
    bit          pat;
    int          total;
  } vec_t;

  vec_t tbl [9];

  int ratio_tb [3];
  int len_tb   [2][3];

  int n_vec = 0;
  int n_err = 0;
  int frames_done [2];

  logic [CH_WIDTH-1:0] words [NUM_CH][160];
  int                  nw    [NUM_CH];
  int                  ptr   [NUM_CH];
  logic [8:0]          exp_q [$];
  int                  got   [$];

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int lowest_onehot(input logic [2:0] m);
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) return (1 << c);
    end
    return 0;
  endfunction

  // One frame on instance k. abort > 0 stops after that many output words.
  task automatic run_frame(input int k, input logic [2:0] mask, input logic [2:0] nxt,
                           input bit tog, input int vpct, input bit pat,
                           input int abort, output int nout);
    logic [8:0]          tmp;
    logic [CH_WIDTH-1:0] w;
    logic [2:0]          ready_seen;
    bit                  started, held, held_last;
    logic [7:0]          held_data;
    int                  cyc, hs, first_cyc, last_cyc, sz, n;

    exp_q.delete();
    got.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      nw[c]  = mask[c] ? (len_tb[k][c] + ratio_tb[c] - 1) / ratio_tb[c] : 0;
      ptr[c] = 0;
      for (int i = 0; i < nw[c]; i++) begin
        w = {$urandom, $urandom, $urandom};
        if (pat && c == 1 && i == 0) begin
          for (int b = 0; b < 12; b++) w[b*8 +: 8] = 8'(b);
        end
        words[c][i] = w;
      end
      n = 0;
      for (int i = 0; i < nw[c]; i++) begin
        w = words[c][i];
        for (int s = 0; s < ratio_tb[c]; s++) begin
          if (n < len_tb[k][c]) begin
            exp_q.push_back({1'b0, w[s*8 +: 8]});
            n++;
          end
        end
      end
    end
    tmp = exp_q.pop_back();
    tmp[8] = 1'b1;
    exp_q.push_back(tmp);

    ch_en[k]   = mask;
    ready_seen = '0;
    started    = 0;
    held       = 0;
    held_data  = '0;
    held_last  = 0;
    cyc = 0; hs = 0; first_cyc = 0; last_cyc = 0;

    while (exp_q.size() > 0 && (abort == 0 || hs < abort) && cyc < 4000) begin
      @(negedge clk);
      sz = exp_q.size();
      if (started) ch_en[k] = (sz <= 2) ? nxt : NUM_CH'($urandom);
      out_ready[k] = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[k][c] = (ptr[c] < nw[c]) && ($urandom_range(0, 99) < vpct);
        in_data[k][c*CH_WIDTH +: CH_WIDTH] = words[c][(ptr[c] < nw[c]) ? ptr[c] : 0];
      end
      #1;
      chk("ready_onehot", int'($countones(in_ready[k]) <= 1), 1);
      if (sz > 1) ready_seen = ready_seen | in_ready[k];
      if (held) begin
        chk("hold_valid", int'(out_valid[k]), 1);
        chk("hold_data", int'(out_data[k]), int'(held_data));
        chk("hold_last", int'(out_last[k]), int'(held_last));
      end
      held      = out_valid[k] && !out_ready[k];
      held_data = out_data[k];
      held_last = out_last[k];
      if (out_valid[k] && out_ready[k]) begin
        tmp = exp_q.pop_front();
        if (sz == 1 && !tog && vpct == 100) chk("idle_at_last", int'(in_ready[k]), 0);
        chk("out_data", int'(out_data[k]), int'(tmp[7:0]));
        chk("out_last", int'(out_last[k]), int'(tmp[8]));
        got.push_back(int'(out_data[k]));
        if (!started) first_cyc = cyc;
        last_cyc = cyc;
        started  = 1;
        hs++;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[k][c] && in_ready[k][c]) ptr[c]++;
      end
      cyc++;
    end
    nout = hs;
    if (abort != 0) return;

    chk("frame_timeout", exp_q.size(), 0);
    chk("ready_outside_mask", int'(ready_seen & ~mask), 0);
    for (int c = 0; c < NUM_CH; c++) chk("words_consumed", ptr[c], nw[c]);
    if (!tog && vpct == 100) chk("throughput_span", last_cyc - first_cyc + 1, hs);

    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) in_valid[k][c] = 1'b0;
    out_ready[k] = 1'b1;
    #1;
    chk("next_frame_ready", int'(in_ready[k]), lowest_onehot(nxt));
    chk("idle_out_valid", int'(out_valid[k]), 0);
    frames_done[k]++;
`ifdef LDPC_CONCAT_STATS_EN
    chk("frame_count", int'(frame_cnt[k]), frames_done[k]);
`endif
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    ratio_tb  = '{1, 12, 12};
    len_tb[0] = '{144, 12, 132};
    len_tb[1] = '{144, 12, 130};

    //           inst mask    next    tog   vpct pat   total
    tbl[0] = '{0, 3'b111, 3'b111, 1'b0, 100, 1'b0, 288};
    tbl[1] = '{0, 3'b111, 3'b101, 1'b1, 100, 1'b0, 288};
    tbl[2] = '{0, 3'b101, 3'b010, 1'b0, 100, 1'b0, 276};
    tbl[3] = '{0, 3'b010, 3'b011, 1'b0, 100, 1'b1, 12};
    tbl[4] = '{0, 3'b011, 3'b100, 1'b1, 70,  1'b0, 156};
    tbl[5] = '{0, 3'b100, 3'b000, 1'b1, 60,  1'b0, 132};
    tbl[6] = '{1, 3'b111, 3'b111, 1'b0, 100, 1'b0, 286};
    tbl[7] = '{1, 3'b111, 3'b001, 1'b1, 80,  1'b0, 286};
    tbl[8] = '{1, 3'b001, 3'b000, 1'b0, 100, 1'b0, 144};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data[k]     = '0;
      in_valid[k]    = '0;
      ch_en[k]       = '0;
      out_ready[k]   = 1'b1;
      frames_done[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid[0]), 0);
    chk("reset_out_data", int'(out_data[0]), 0);
    chk("reset_out_last", int'(out_last[0]), 0);
    chk("reset_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 9; t++) begin
      run_frame(tbl[t].inst, tbl[t].mask, tbl[t].nxt, tbl[t].tog, tbl[t].vpct,
                tbl[t].pat, 0, n);
      chk("frame_words", n, tbl[t].total);
      if (tbl[t].pat) begin
        for (int i = 0; i < 12; i++) chk("pattern_order", got[i], i);
      end
    end

    // Reset in the middle of a frame, after 100 output words.
    run_frame(0, 3'b111, 3'b111, 1'b0, 100, 1'b0, 100, n);
    chk("abort_words", n, 100);
    @(negedge clk);
    in_valid[0] = '0;
    in_valid[1] = '0;
    out_ready[0] = 1'b0;
    #1;
    chk("pre_reset_valid", int'(out_valid[0]), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", int'(out_valid[0]), 0);
    chk("mid_reset_out_data", int'(out_data[0]), 0);
    chk("mid_reset_out_last", int'(out_last[0]), 0);
    chk("mid_reset_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    out_ready[0] = 1'b1;
    ch_en[0] = 3'b111;
    ch_en[1] = 3'b000;
    frames_done[0] = 0;
    frames_done[1] = 0;
    rst = 1'b0;
`ifdef LDPC_CONCAT_STATS_EN
    #1;
    chk("frame_count_after_reset", int'(frame_cnt[0]), 0);
`endif
    run_frame(0, 3'b111, 3'b000, 1'b1, 90, 1'b0, 0, n);
    chk("post_reset_frame_words", n, 288);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
